core_lsu: RTL
=============

Name: core_lsu

Overview:
- Load/store unit directly downstream of the execute-stage ALU.
- Takes the registered effective address (ALU RESULT = RS1+IMM) together with the one-hot load/store flags and RS2.
- Performs one word-aligned data-bus transaction with a REQ/READY handshake, byte-lane steering and load sign/zero extension.
- Reports completion, misalignment or bus timeout to the core control.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles D_REQ may stay high without D_READY before abort; 1..65535.

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  one-cycle pulse: ADDR, RS2 and op flags are valid this cycle
- I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW  in  1 each  one-hot op select, sampled with START
- ADDR  in  32  effective byte address (ALU RESULT)
- RS2  in  32  store source data
- D_REQ  out  1  bus request, held until accepted
- D_WE  out  1  1 = write
- D_ADDR  out  32  word address, {ADDR[31:2],2'b00}
- D_BE  out  4  byte enables (loads and stores)
- D_WDATA  out  32  lane-replicated store data
- D_RDATA  in  32  read data, valid when D_READY=1 and D_WE=0
- D_READY  in  1  bus accepts/completes the transaction this cycle
- BUSY  out  1  high from the cycle after an accepted START until DONE/EXC cycle inclusive
- DONE  out  1  one-cycle pulse: transaction completed successfully
- LOAD_DATA  out  32  extended load result; valid with DONE for loads; 0 for stores
- MISALIGNED  out  1  one-cycle pulse: misaligned access, no bus transaction
- BUS_ERR  out  1  one-cycle pulse: timeout abort
- EXC_ADDR  out  32  ADDR of faulting op; valid with MISALIGNED/BUS_ERR

Behaviour:
- Reset (RST_N low, asynchronous): state IDLE; all outputs 0; timeout counter 0.
  - Mid-transaction reset drops D_REQ immediately with no further pulses.
- States: IDLE, REQ, FIN, EXC.
- IDLE:
  - START with exactly one op flag set: latch op, ADDR and RS2.
    - Misaligned → EXC.
    - Otherwise → REQ.
  - START with zero flags or more than one flag: ignored, stay IDLE.
  - START outside IDLE: ignored.
- Misalignment:
  - LH/LHU/SH with ADDR[0]=1.
  - LW/SW with ADDR[1:0]≠0.
  - Byte ops are never misaligned.
- REQ:
  - D_REQ=1; D_WE, D_ADDR, D_BE and D_WDATA stay stable every cycle until acceptance.
  - D_READY=1: capture D_RDATA → FIN. READY in the first REQ cycle is legal, giving minimum latency START→DONE = 2 cycles.
  - Counter increments each REQ cycle without READY; reaching TIMEOUT_CYCLES → EXC with BUS_ERR. READY in the same cycle the count would expire wins.
- FIN: DONE=1 and LOAD_DATA valid for one cycle → IDLE.
- EXC: exactly one of MISALIGNED or BUS_ERR = 1, EXC_ADDR valid, D_REQ=0 → IDLE.
- Lane steering, with o = ADDR[1:0]:
  - Byte ops: D_BE = 4'b0001<<o; D_WDATA = {4{RS2[7:0]}}.
  - Half ops: D_BE = o[1] ? 4'b1100 : 4'b0011; D_WDATA = {2{RS2[15:0]}}.
  - Word ops: D_BE = 4'b1111; D_WDATA = RS2.
- Load extract:
  - Byte = D_RDATA[8*o+:8]; half = D_RDATA[16*o[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes D_RDATA unchanged.
- Idle bus outputs: D_WE/D_BE/D_WDATA are 0 whenever D_REQ=0.
- Outputs other than pulses hold their last value except LOAD_DATA, which is cleared to 0 on the next START.

Test Plan:
- LW, ADDR=0x0000_1004, D_READY high on first REQ cycle, D_RDATA=0xDEAD_BEEF → D_ADDR=0x1004, D_BE=1111, DONE two cycles after START, LOAD_DATA=0xDEAD_BEEF.
- LB then LBU at ADDR=0x2003, D_RDATA=0x8000_0000 → LB LOAD_DATA=0xFFFF_FF80, LBU=0x0000_0080; D_BE=1000 for both.
- SH, ADDR=0x3002, RS2=0x1234_ABCD, D_READY delayed 5 cycles → D_REQ held 6 cycles with D_BE=1100, D_WDATA=0xABCD_ABCD stable, D_WE=1; DONE once; LOAD_DATA=0.
- SW, ADDR=0x4001 → no D_REQ; MISALIGNED pulse one cycle after START with EXC_ADDR=0x4001; then LH, ADDR=0x4001 → MISALIGNED again.
- TIMEOUT_CYCLES=4, LW with D_READY held low → D_REQ high exactly 4 cycles, then BUS_ERR pulse with EXC_ADDR; a second START issued during BUSY is ignored.
- Assert RST_N low mid-REQ → D_REQ/BUSY fall without waiting for a clock edge; no DONE/BUS_ERR; after release, a new SB, ADDR=0x0, RS2=0xAA completes with D_BE=0001, D_WDATA=0xAAAA_AAAA.

Source files
------------

// File: rtl/core_lsu.sv
// Load/store unit behind the execute-stage ALU: one word-aligned REQ/READY bus
// transaction per op, with byte-lane steering, load extension and timeout abort.
module core_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        I_LB,
    input  logic        I_LH,
    input  logic        I_LW,
    input  logic        I_LBU,
    input  logic        I_LHU,
    input  logic        I_SB,
    input  logic        I_SH,
    input  logic        I_SW,
    input  logic [31:0] ADDR,
    input  logic [31:0] RS2,
    output logic        D_REQ,
    output logic        D_WE,
    output logic [31:0] D_ADDR,
    output logic [3:0]  D_BE,
    output logic [31:0] D_WDATA,
    input  logic [31:0] D_RDATA,
    input  logic        D_READY,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] LOAD_DATA,
    output logic        MISALIGNED,
    output logic        BUS_ERR,
    output logic [31:0] EXC_ADDR
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FIN, S_EXC} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    acc_size_t   size_q, size_d;
    logic        sext_q, sext_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic        bus_err_q, bus_err_d;

    logic [7:0]  op_flags;
    logic        op_onehot;
    acc_size_t   start_size;
    logic        start_store;
    logic        start_sext;
    logic        start_misal;
    logic [3:0]  start_be;
    logic [31:0] start_wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic        req_active;

    assign op_flags  = {I_SW, I_SH, I_SB, I_LHU, I_LBU, I_LW, I_LH, I_LB};
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign op_onehot = (op_flags != 8'd0) && ((op_flags & (op_flags - 8'd1)) == 8'd0);

    assign start_store = I_SB | I_SH | I_SW;
    assign start_sext  = I_LB | I_LH;

    always_comb begin
        start_size = SZ_WORD;
        if (I_LB || I_LBU || I_SB) begin
            start_size = SZ_BYTE;
        end else if (I_LH || I_LHU || I_SH) begin
            start_size = SZ_HALF;
        end
    end

    always_comb begin
        start_misal = 1'b0;
        start_be    = 4'b1111;
        start_wdata = RS2;
        case (start_size)
            SZ_BYTE: begin
                start_be    = 4'b0001 << ADDR[1:0];
                start_wdata = {4{RS2[7:0]}};
            end
            SZ_HALF: begin
                start_misal = ADDR[0];
                start_be    = ADDR[1] ? 4'b1100 : 4'b0011;
                start_wdata = {2{RS2[15:0]}};
            end
            default: begin
                start_misal = (ADDR[1:0] != 2'b00);
            end
        endcase
        if (!start_store) begin
            start_wdata = '0;
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = D_RDATA[7:0];
            2'd1:    rd_byte = D_RDATA[15:8];
            2'd2:    rd_byte = D_RDATA[23:16];
            default: rd_byte = D_RDATA[31:24];
        endcase
        rd_half = addr_q[1] ? D_RDATA[31:16] : D_RDATA[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{24{sext_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_ext = {{16{sext_q & rd_half[15]}}, rd_half};
            default: load_ext = D_RDATA;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        sext_d     = sext_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        load_d     = load_q;
        exc_addr_d = exc_addr_q;
        bus_err_d  = bus_err_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    load_d = '0;
                    if (op_onehot) begin
                        addr_d  = ADDR;
                        size_d  = start_size;
                        sext_d  = start_sext;
                        we_d    = start_store;
                        be_d    = start_be;
                        wdata_d = start_wdata;
                        if (start_misal) begin
                            exc_addr_d = ADDR;
                            bus_err_d  = 1'b0;
                            state_d    = S_EXC;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                // READY takes priority over a timeout expiring in the same cycle.
                if (D_READY) begin
                    load_d  = we_q ? 32'd0 : load_ext;
                    cnt_d   = '0;
                    state_d = S_FIN;
                end else if (cnt_q + 16'd1 == TIMEOUT_LIM) begin
                    exc_addr_d = addr_q;
                    bus_err_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_EXC;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            size_q     <= SZ_BYTE;
            sext_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            load_q     <= '0;
            exc_addr_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            load_q     <= load_d;
            exc_addr_q <= exc_addr_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Bus and status outputs decode straight from the state register so an
    // asynchronous reset drops them without waiting for a clock edge.
    assign req_active = (state_q == S_REQ);
    assign D_REQ      = req_active;
    assign D_WE       = req_active & we_q;
    assign D_ADDR     = {addr_q[31:2], 2'b00};
    assign D_BE       = req_active ? be_q : 4'b0000;
    assign D_WDATA    = req_active ? wdata_q : 32'd0;
    assign BUSY       = (state_q != S_IDLE);
    assign DONE       = (state_q == S_FIN);
    assign LOAD_DATA  = load_q;
    assign MISALIGNED = (state_q == S_EXC) & ~bus_err_q;
    assign BUS_ERR    = (state_q == S_EXC) & bus_err_q;
    assign EXC_ADDR   = exc_addr_q;

endmodule
